// File: rtl/seq_mult.sv
// Folded shift-add multiplier: one partial-product row per clock into a 2*WIDTH accumulator.
// Define SEQ_MULT_SIGNED_EN to build the two's-complement path (sign extension + last-row subtract).
module seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             x,
    input  logic [WIDTH-1:0]             y,
    input  logic                         is_signed,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2*WIDTH-1:0]           out,
    output logic [2*WIDTH-1:0]           pp,
    output logic [$clog2(WIDTH+1)-1:0]   row
);

    localparam int RW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [RW-1:0] LAST = RW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [RW-1:0]    r_row;

    logic             w_sgn_in;
    logic [PW-1:0]    w_xe;
    logic [PW-1:0]    w_sum;

`ifdef SEQ_MULT_SIGNED_EN
    logic r_sgn;

    assign w_sgn_in = is_signed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sgn <= 1'b0;
        end else if (r_state == S_IDLE && in_valid) begin
            r_sgn <= is_signed;
        end
    end

    // MSB of a signed multiplier carries weight -2^(WIDTH-1)
    assign w_sum = (r_sgn && r_row == LAST) ? r_acc - r_mcand
                                            : r_acc + r_mcand;
`else
    logic w_unused;

    assign w_unused = is_signed;
    assign w_sgn_in = 1'b0;
    assign w_sum    = r_acc + r_mcand;
`endif

    assign w_xe = {{WIDTH{w_sgn_in & x[WIDTH-1]}}, x};

    // r_mcand holds xe << row and r_mplier holds y >> row, so no variable shifter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_row    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_acc    <= '0;
                        r_mcand  <= w_xe;
                        r_mplier <= y;
                        r_row    <= '0;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_mplier[0]) begin
                        r_acc <= w_sum;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_row    <= r_row + RW'(1);
                    if (r_row == LAST) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out       = r_acc;
    assign pp        = r_acc;
    assign row       = r_row;

endmodule

// File: doc/seq_mult.md
# seq_mult

Parametrised, folded successor to the 8x8 carry-save array multiplier. Processes one partial-product row per clock through a single 2·WIDTH-bit accumulator instead of WIDTH rows of full adders. Supports unsigned and two's-complement operands, uses valid/ready handshakes on both sides, and exposes the running partial sum so the automarker can check every row. Sits between operand-producing datapath logic and any consumer that can tolerate a WIDTH+1-cycle latency in exchange for area.

## Interface
- `WIDTH`, default 8: operand width in bits; legal values are ≥ 2. The product is 2·WIDTH bits.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operands are valid.
- `in_ready`  out  1  block can accept operands.
- `x`  in  WIDTH  multiplicand.
- `y`  in  WIDTH  multiplier.
- `is_signed`  in  1  treat `x` and `y` as two's-complement; sampled at accept.
- `out_valid`  out  1  `out` holds a finished product.
- `out_ready`  in  1  consumer takes the product.
- `out`  out  2·WIDTH  product.
- `pp`  out  2·WIDTH  current accumulator, i.e. the partial sum after the last completed row.
- `row`  out  $clog2(WIDTH+1)  number of rows completed.

## Operation
- The state machine has three states: IDLE, BUSY and DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`:
    - latch `x`, `y` and `is_signed`;
    - clear the accumulator to 0 and set `row`=0;
    - go to BUSY.
- **BUSY** (for `row` = i, one row per cycle)
  - Let `xe` be `x` extended to 2·WIDTH bits: sign-extended if signed, zero-extended if not.
  - If y[i]=1, the accumulator becomes accumulator + (`xe` << i).
  - Exception: when i = WIDTH−1 and signed, the row is subtracted instead, because the MSB of `y` has weight −2^(WIDTH−1).
  - All arithmetic is modulo 2^(2·WIDTH); carries out of the MSB are discarded.
  - `row` increments after each row.
  - After row WIDTH−1 completes, `row`=WIDTH and the FSM goes to DONE.
- **DONE**
  - `out_valid`=1 and `out` = accumulator.
  - `out` and `out_valid` stay stable until `out_ready`=1.
  - On `out_ready`, go to IDLE.
- `in_ready`=0 in BUSY and DONE. Operands presented then are ignored and not queued.
- `out` = accumulator in every state; it is only meaningful when `out_valid`=1.
- A change on `x`, `y` or `is_signed` after the accept cycle has no effect.

## Timing
- **Reset values:**
  - state=IDLE
  - `in_ready`=1
  - `out_valid`=0
  - `out`=0, `pp`=0
  - `row`=0
- **Latency:** accept on edge 0; rows complete on edges 1..WIDTH; `out_valid` is high after edge WIDTH.
- **Throughput:** at most one product every WIDTH+2 cycles with `out_ready` held high (accept, WIDTH rows, one DONE cycle).
- **Back-to-back:** `in_ready` rises the cycle after the DONE handshake. There is no same-cycle re-accept in DONE.
- **Reset mid-operation** (BUSY or DONE): abort immediately to the reset values. The pending product is lost and no `out_valid` pulse is produced.
- **`in_valid` held across cycles:** accepted exactly once per IDLE visit.
- **`out_ready` already high when DONE is entered:** the handshake completes on the first DONE cycle.
- **Width edge cases:**
  - 0·anything = 0.
  - Unsigned (2^W−1)² must not overflow 2·WIDTH bits.
  - Signed (−2^(W−1))² = 2^(2W−2), which is positive and representable.

## Configuration
- `SEQ_MULT_SIGNED_EN`
  - **Defined:** the `is_signed` path is compiled in (sign extension and final-row subtraction), as described above.
  - **Undefined:**
    - the `is_signed` port still exists but is ignored;
    - all operands are treated as unsigned;
    - no subtractor is built;
    - latency and handshake are unchanged.

## Test plan
- WIDTH=8, unsigned x=255, y=255 → `out`=0xFE01 exactly 8 cycles after accept; `pp` after row 0 = 0x00FF.
- WIDTH=8, signed x=0x80, y=0x80 → 0x4000. Signed x=0xFF, y=0x7F → 0xFF81. With the macro undefined, the same signed inputs give unsigned results 0x4000 and 0x7E81.
- WIDTH=8, x=0, y=0xA5 → 0x0000. Also check that `row` steps 0..8 and `in_ready`=0 throughout BUSY.
- Hold `out_ready`=0 for 5 cycles in DONE → `out`/`out_valid` stable. Toggling `in_valid`/`x` meanwhile has no effect. Raising `out_ready` → IDLE the next cycle.
- Assert `reset` during row 4 of 200·100 → all outputs return to reset values at once, and no `out_valid` appears. Then 3·7 → 21.
- WIDTH=16 random 1000 pairs, both modes, against a reference model; `out_ready` randomised.
